// File: rtl/random_target_spawner.sv
// rtl/random_target_spawner.sv - draws random slots from the generator and keeps the active-target mask
// Optional macro SPAWN_TIMER_EN adds a periodic auto-spawn request every SPAWN_PERIOD cycles.
module random_target_spawner #(
    parameter int NUM_SLOTS    = 10,
    parameter int MAX_RETRIES  = 3,
    parameter int SPAWN_PERIOD = 50000000
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 spawnRequest,
    input  logic [NUM_SLOTS-1:0] targetHit,
    input  logic [3:0]           randomNumber,
    output logic                 getRandomNumber,
    output logic [NUM_SLOTS-1:0] targetMask,
    output logic                 spawnDone,
    output logic [3:0]           spawnSlot,
    output logic                 busy,
    output logic                 full
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_SCAN  = 3'd4;

    localparam int             RW        = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [3:0]     SLOTS     = 4'(NUM_SLOTS);
    localparam logic [3:0]     SLOT_LAST = 4'(NUM_SLOTS - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [RW-1:0]        retry_cnt;
    logic                 pending;
    logic [3:0]           scan_idx;
    logic                 spawn_req;
    logic [15:0]          mask_ext;
    logic                 draw_ok;
    logic                 scan_ok;
    logic                 place;
    logic [3:0]           place_idx;
    logic [NUM_SLOTS-1:0] place_vec;

`ifdef SPAWN_TIMER_EN
    localparam int            TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    logic [TW-1:0] timer_cnt;
    logic          timer_tick;

    assign timer_tick = (timer_cnt == TW'(SPAWN_PERIOD - 1));
    assign spawn_req  = spawnRequest | timer_tick;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timer_cnt <= '0;
        end else begin
            timer_cnt <= timer_tick ? '0 : timer_cnt + TW'(1);
        end
    end
`else
    assign spawn_req = spawnRequest;
`endif

    // Zero-extended view so 4-bit draws 10..15 can be indexed safely; they are rejected by the range test.
    assign mask_ext  = 16'(targetMask);
    assign draw_ok   = (randomNumber < SLOTS) && !mask_ext[randomNumber];
    assign scan_ok   = !mask_ext[scan_idx];
    assign place     = ((state == S_CHECK) && draw_ok) || ((state == S_SCAN) && scan_ok);
    assign place_idx = (state == S_SCAN) ? scan_idx : randomNumber;

    assign getRandomNumber = (state == S_REQ);
    assign spawnDone       = place;
    assign busy            = (state != S_IDLE);
    assign full            = &targetMask;

    always_comb begin
        place_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            place_vec[i] = place && (place_idx == 4'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if ((spawn_req || pending) && !full) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_CHECK;
            S_CHECK: begin
                if (draw_ok)                      state_nxt = S_IDLE;
                else if (retry_cnt < RETRY_MAX)   state_nxt = S_REQ;
                else                              state_nxt = S_SCAN;
            end
            S_SCAN:  if (scan_ok || full) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            targetMask <= '0;
            spawnSlot  <= 4'd0;
            retry_cnt  <= '0;
            pending    <= 1'b0;
            scan_idx   <= 4'd0;
        end else begin
            state      <= state_nxt;
            // Hits clear every cycle; a placement into the same slot still sets it.
            targetMask <= (targetMask & ~targetHit) | place_vec;
            if (place) spawnSlot <= place_idx;

            if (state == S_IDLE)
                retry_cnt <= '0;
            else if ((state == S_CHECK) && !draw_ok && (retry_cnt < RETRY_MAX))
                retry_cnt <= retry_cnt + RW'(1);

            if (state == S_CHECK)
                scan_idx <= (randomNumber >= SLOTS) ? 4'd0 : randomNumber;
            else if (state == S_SCAN)
                scan_idx <= (scan_idx == SLOT_LAST) ? 4'd0 : scan_idx + 4'd1;

            // One-deep: the IDLE state consumes (or drops, when full) whatever was queued.
            if (state == S_IDLE)
                pending <= 1'b0;
            else if (spawn_req)
                pending <= 1'b1;
        end
    end

endmodule
